// File: rtl/de0_nano_leds_scheduler.sv
// Round-robin scheduler sharing the DE0-Nano 8-LED driver among several
// requesters. The granted owner keeps the display for a minimum number of
// enabled cycles; its byte is forwarded with a one-shot update strobe.
module de0_nano_leds_scheduler #(
    parameter int REQUESTERS  = 4,
    parameter int HOLD_CYCLES = 1_000_000
) (
    input  logic                            clk,
    input  logic                            async_rst,
    input  logic                            clk_en,
    input  logic [REQUESTERS-1:0]           req_valid,
    input  logic [REQUESTERS*8-1:0]         req_data,
    output logic [REQUESTERS-1:0]           req_ready,
    output logic [7:0]                      data_out,
    output logic                            update_out,
    output logic [$clog2(REQUESTERS)-1:0]   owner_out,
    output logic                            busy
);

    localparam int OW = $clog2(REQUESTERS);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [OW-1:0] LAST_IDX    = OW'(REQUESTERS - 1);
    localparam logic [OW:0]   N_WIDE      = (OW+1)'(REQUESTERS);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   ptr, ptr_nxt;
    logic [OW-1:0]   owner, owner_nxt;
    logic [CW-1:0]   hold_cnt, hold_nxt;
    logic [7:0]      data_nxt;
    logic            update_nxt;
    logic [OW-1:0]   grant;
    logic            grant_found;
    logic [OW:0]     scan_idx;

    // Round-robin search: first valid index starting at ptr, wrapping modulo REQUESTERS
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            scan_idx = {1'b0, ptr} + (OW+1)'(k);
            if (scan_idx >= N_WIDE) begin
                scan_idx = scan_idx - N_WIDE;
            end
            if (!grant_found && req_valid[scan_idx[OW-1:0]]) begin
                grant_found = 1'b1;
                grant       = scan_idx[OW-1:0];
            end
        end
    end

    // Next-state, accept handshake and strobe logic
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        hold_nxt   = hold_cnt;
        data_nxt   = data_out;
        update_nxt = update_out;
        req_ready  = '0;
        if (clk_en) begin
            // The strobe lives for exactly one enabled cycle unless re-armed below.
            update_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        req_ready[grant] = 1'b1;
                        data_nxt         = req_data[{grant, 3'b000} +: 8];
                        update_nxt       = 1'b1;
                        owner_nxt        = grant;
                        hold_nxt         = HOLD_RELOAD;
                        state_nxt        = HOLD;
                    end
                end
                HOLD: begin
                    // The owner's own re-request wins over expiry and restarts the hold.
                    if (req_valid[owner]) begin
                        req_ready[owner] = 1'b1;
                        data_nxt         = req_data[{owner, 3'b000} +: 8];
                        update_nxt       = 1'b1;
                        hold_nxt         = HOLD_RELOAD;
                    end else if (hold_cnt != '0) begin
                        hold_nxt = hold_cnt - 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        ptr_nxt   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        // Nothing may be accepted while reset is held.
        if (async_rst) begin
            req_ready = '0;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            hold_cnt   <= '0;
            data_out   <= 8'h00;
            update_out <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            owner      <= owner_nxt;
            hold_cnt   <= hold_nxt;
            data_out   <= data_nxt;
            update_out <= update_nxt;
        end
    end

    assign busy      = (state == HOLD);
    assign owner_out = owner;

endmodule

// File: tb/tb_de0_nano_leds_scheduler.sv
// Directed bench for de0_nano_leds_scheduler with 4 requesters and a
// 4-cycle hold.
module tb_de0_nano_leds_scheduler;

    localparam int N = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         async_rst;
    logic         clk_en;
    logic [N-1:0] req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0] req_ready;
    logic [7:0]   data_out;
    logic         update_out;
    logic [1:0]   owner_out;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    de0_nano_leds_scheduler #(.REQUESTERS(N), .HOLD_CYCLES(H)) dut (
        .clk        (clk),
        .async_rst  (async_rst),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .data_out   (data_out),
        .update_out (update_out),
        .owner_out  (owner_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        async_rst = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        @(negedge clk);
        @(negedge clk);
        async_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        async_rst = 1'b1;
        clk_en    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        #1;
        n_cmp++;
        if ({data_out, update_out, busy, owner_out, req_ready} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_initial: got %h required 0", {data_out, update_out, busy, owner_out, req_ready});
        end
        @(negedge clk);
        async_rst = 1'b0;
        tick();
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_pre_grant: ready=%b required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (data_out !== 8'hA5 || busy !== 1'b1 || update_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_pre_hold: data=%h busy=%b upd=%b required A5 1 1", data_out, busy, update_out);
        end
        tick();
        // Assert reset mid-hold with a pending non-owner request, away from any edge.
        req_valid = 4'b0010;
        async_rst = 1'b1;
        #1;
        n_cmp++;
        if ({data_out, update_out, busy, owner_out} !== 12'h0) begin
            n_bad++;
            $display("FAIL reset_async_clear: data=%h upd=%b busy=%b owner=%0d required all 0",
                     data_out, update_out, busy, owner_out);
        end
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ready_gated: ready=%b required 0000", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        async_rst = 1'b0;
        tick();
        req_data[7:0] = 8'h3C;
        req_valid     = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_post_grant: ready=%b required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (data_out !== 8'h3C || owner_out !== 2'd0 || update_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_post_data: data=%h owner=%0d upd=%b required 3C 0 1", data_out, owner_out, update_out);
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data[23:16] = 8'h81;
        req_valid       = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_ready: ready=%b required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (data_out !== 8'h81 || update_out !== 1'b1 || busy !== 1'b1 || owner_out !== 2'd2) begin
            n_bad++;
            $display("FAIL single_accept: data=%h upd=%b busy=%b owner=%0d required 81 1 1 2",
                     data_out, update_out, busy, owner_out);
        end
        for (int k = 0; k < H - 1; k++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b1 || update_out !== 1'b0 || data_out !== 8'h81) begin
                n_bad++;
                $display("FAIL single_hold%0d: busy=%b upd=%b data=%h required 1 0 81", k, busy, update_out, data_out);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_release: busy=%b required 0", busy);
        end
    endtask

    task automatic test_fairness();
        int e;
        int gap;
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        #1;
        for (int n = 0; n < 5; n++) begin
            e = n % N;
            n_cmp++;
            if (req_ready !== 4'(1 << e)) begin
                n_bad++;
                $display("FAIL fair_grant%0d: ready=%b required %b", n, req_ready, 4'(1 << e));
            end
            tick();
            req_valid[e] = 1'b0;
            #1;
            n_cmp++;
            if (data_out !== 8'(8'h10 + e) || owner_out !== 2'(e)) begin
                n_bad++;
                $display("FAIL fair_data%0d: data=%h owner=%0d required %h %0d", n, data_out, owner_out, 8'(8'h10 + e), e);
            end
            if (n < 4) begin
                gap = 1;
                while (req_ready === 4'b0000 && gap < 20) begin
                    tick();
                    gap++;
                end
                n_cmp++;
                if (gap !== H + 1) begin
                    n_bad++;
                    $display("FAIL fair_gap%0d: gap=%0d required %0d", n, gap, H + 1);
                end
                req_valid[e] = 1'b1;
                #1;
            end
        end
        req_valid = '0;
    endtask

    task automatic test_owner_ext();
        do_reset();
        req_data[15:8] = 8'h77;
        req_valid      = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL ext_first: ready=%b required 0010", req_ready);
        end
        tick();
        req_data[31:24] = 8'hEE;
        req_valid       = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL ext_wait: ready=%b required 0000", req_ready);
        end
        tick();
        tick();
        // hold_cnt is now 1: owner re-requests while requester 3 waits.
        req_data[15:8] = 8'h0F;
        req_valid      = 4'b1010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL ext_reaccept: ready=%b required 0010", req_ready);
        end
        tick();
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (data_out !== 8'h0F || update_out !== 1'b1 || req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL ext_data: data=%h upd=%b ready=%b required 0F 1 0000", data_out, update_out, req_ready);
        end
        for (int k = 0; k < H - 1; k++) begin
            tick();
            n_cmp++;
            if (busy !== 1'b1 || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL ext_reload%0d: busy=%b ready=%b required 1 0000", k, busy, req_ready);
            end
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL ext_handover: busy=%b ready=%b required 0 1000", busy, req_ready);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_clk_en();
        do_reset();
        clk_en          = 1'b0;
        req_data[23:16] = 8'h5A;
        req_valid       = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL en_idle_ready: ready=%b required 0000", req_ready);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || update_out !== 1'b0) begin
            n_bad++;
            $display("FAIL en_idle_hold: busy=%b upd=%b required 0 0", busy, update_out);
        end
        clk_en = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL en_grant: ready=%b required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        for (int k = 1; k <= 12; k++) begin
            clk_en = (k % 3 == 0);
            tick();
            n_cmp++;
            if (update_out !== (k < 3) || busy !== (k < 12) || data_out !== 8'h5A) begin
                n_bad++;
                $display("FAIL en_edge%0d: upd=%b busy=%b data=%h required %b %b 5A",
                         k, update_out, busy, data_out, (k < 3), (k < 12));
            end
        end
        clk_en = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        req_data[31:24] = 8'hC3;
        req_valid       = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_grant3: ready=%b required 1000", req_ready);
        end
        tick();
        req_data[7:0] = 8'h42;
        req_valid     = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000 || owner_out !== 2'd3) begin
            n_bad++;
            $display("FAIL wrap_hold: ready=%b owner=%0d required 0000 3", req_ready, owner_out);
        end
        for (int k = 0; k < H - 1; k++) tick();
        n_cmp++;
        if (req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_last_hold: ready=%b busy=%b required 0000 1", req_ready, busy);
        end
        tick();
        n_cmp++;
        if (req_ready !== 4'b0001 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_ready0: ready=%b busy=%b required 0001 0", req_ready, busy);
        end
        tick();
        req_valid = '0;
        n_cmp++;
        if (owner_out !== 2'd0 || data_out !== 8'h42 || update_out !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_owner0: owner=%0d data=%h upd=%b required 0 42 1", owner_out, data_out, update_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_owner_ext();
        test_clk_en();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/de0_nano_leds_scheduler.md
# de0_nano_leds_scheduler

Round-robin scheduler that shares the DE0-Nano 8-LED driver among several requesters. It grants the display to one requester at a time and holds ownership for a minimum number of enabled cycles so each pattern stays visible. It forwards the owner's byte with an update strobe to the LED driver's `data_in` and `update_leds` inputs. It sits between application logic (status, debug, heartbeat sources) and the LED driver, in the same `clk`/`clk_en` domain.

## Interface
- `REQUESTERS`, default 4: number of requesters. Legal range is 2 to 16.
- `HOLD_CYCLES`, default 1_000_000: minimum ownership time, counted in `clk_en`-qualified cycles. Must be at least 1.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `async_rst` input, 1 bit: reset, asynchronous, active-high.
- `clk_en` input, 1 bit: cycle enable. State advances only when it is high.
- `req_valid` input, `REQUESTERS` bits: bit i means requester i has a byte to display.
- `req_data` input, `REQUESTERS*8` bits: requester i's byte is at `[8*i+7:8*i]`.
- `req_ready` output, `REQUESTERS` bits: combinational. One-hot or zero. Bit i high means the byte is accepted this cycle.
- `data_out` output, 8 bits: registered byte. Connects to the driver's `data_in`.
- `update_out` output, 1 bit: registered update strobe. Connects to the driver's `update_leds`.
- `owner_out` output, `$clog2(REQUESTERS)` bits: index of the current or last owner.
- `busy` output, 1 bit: high while in HOLD state.

## Operation
- Two states, IDLE and HOLD. Registers:
  - `state`
  - round-robin pointer `ptr`
  - `owner`
  - `hold_cnt`, `$clog2(HOLD_CYCLES+1)` bits
  - `data_out`
  - `update_out`
- IDLE, when `clk_en` is high and at least one `req_valid` bit is set:
  - Grant the first valid index found scanning `ptr`, `ptr+1`, … modulo `REQUESTERS`.
  - Assert `req_ready[g]` in the same cycle.
  - On the edge: `data_out` takes `req_data[g]`, `update_out` goes to 1, `owner` becomes `g`, `hold_cnt` becomes `HOLD_CYCLES-1`, state goes to HOLD.
- IDLE with `clk_en` low: `req_ready` is all zeros and nothing changes.
- HOLD, when `clk_en` is high:
  - If `req_valid[owner]` is high: assert `req_ready[owner]`, load `data_out`, set `update_out`, reload `hold_cnt` to `HOLD_CYCLES-1`. The owner's request takes priority over expiry.
  - Otherwise, if `hold_cnt` is nonzero, decrement it.
  - Otherwise (`hold_cnt` is 0): go to IDLE and set `ptr` to `(owner+1) mod REQUESTERS`.
  - Non-owner requests get no `req_ready` and wait. They are not dropped; the requester keeps `req_valid` and `req_data` stable until it sees ready.
- `update_out` clears on the first `clk_en`-high cycle after it was set, unless a new accept sets it again in that same cycle. This guarantees the driver samples the strobe exactly once per accept under any `clk_en` pattern.
- Arbitration happens only in IDLE. There is no same-cycle handover from HOLD expiry to a new grant.
- `busy` equals `(state == HOLD)`. `owner_out` equals `owner`.

## Timing
- Reset values, held while `async_rst` is high and cleared independent of `clk`:
  - `state` is IDLE.
  - `ptr`, `owner`, `owner_out`, `hold_cnt` are 0.
  - `data_out` is 0x00.
  - `update_out` and `busy` are 0.
  - `req_ready` is all zeros.
- Reset asserted during HOLD aborts ownership. No strobe is issued, and no pending request counts as accepted.
- Latency with `clk_en` held high:
  - Accept cycle is T (`req_ready` high).
  - `data_out` and `update_out` are valid at T+1.
  - The driver's LEDs change at T+3, after its state register and output buffer.
- Hold length with `clk_en` continuously high and no re-request: HOLD occupies exactly `HOLD_CYCLES` cycles after the accept edge. The earliest next grant is at T+`HOLD_CYCLES`+1.
- `HOLD_CYCLES`=1: `hold_cnt` loads 0, so HOLD lasts one enabled cycle.
- `ptr` wraps from `REQUESTERS-1` to 0.
- If all requesters are valid, each is granted in turn with no starvation. The worst-case wait is `(REQUESTERS-1)·(HOLD_CYCLES+1)` enabled cycles, assuming owners do not re-request.

## Test plan
- Reset: drive `async_rst` high mid-HOLD with `data_out`=0xA5 → all outputs go to 0 and state goes to IDLE without a `clk` edge. After release, a `req_valid[0]` with byte 0x3C is granted by requester 0.
- Single requester, `HOLD_CYCLES`=4, `clk_en`=1: `req_valid[2]` with byte 0x81 → `req_ready[2]` at T, `data_out`=0x81 and `update_out`=1 at T+1 for one cycle, `busy` high for 4 cycles then low.
- Fairness, `REQUESTERS`=4: all valid continuously, single-cycle requests, re-raised after each accept → grant order is 0,1,2,3,0. Each grant is separated by `HOLD_CYCLES`+1 cycles.
- Owner extension: owner 1 re-requests (byte 0x0F) with `hold_cnt`=1 while requester 3 is waiting → owner 1 is accepted, `hold_cnt` reloads, and `req_ready[3]` stays 0.
- `clk_en` toggling (1 high in 3 cycles) → each `update_out` pulse covers exactly one `clk_en`-high cycle, and hold is counted only in enabled cycles.
- Wrap: last owner 3 with only requester 0 valid at expiry → `ptr`=0, and requester 0 is granted on the next enabled IDLE cycle.
